// File: rtl/reg_dump_reader_pkg.sv
// Shared definitions for register-file users: index width, register count and
// the dump reader's FSM state encoding.
package reg_dump_reader_pkg;

  localparam int REG_COUNT = 32;
  localparam int IDX_W     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks a register-file read port from first_idx to last_idx
// (inclusive, wrapping 31 -> 0) and presents each word on a valid/ready port.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin a dump (only honoured in IDLE)
//   first_idx/last_idx  dump range, captured when start is accepted
//   abort             cancel a dump in progress (READ or SEND)
//   rf_rs / rf_data   register-file read address / combinational read data
//   out_valid/out_ready/out_index/out_data   word output handshake
//   busy              high in READ and SEND
//   done              one-cycle pulse after the last word is accepted
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int n = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] first_idx,
  input  logic [IDX_W-1:0] last_idx,
  input  logic             abort,
  output logic [IDX_W-1:0] rf_rs,
  input  logic [n-1:0]     rf_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [n-1:0]     out_data,
  output logic             busy,
  output logic             done
);

  state_e           state_q;
  logic [IDX_W-1:0] cur_q;
  logic [IDX_W-1:0] end_q;
  logic [IDX_W-1:0] out_index_q;
  logic [n-1:0]     out_data_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             done_q;

  // The read port is only addressed while a word is being fetched.
  assign rf_rs     = (state_q == READ) ? cur_q : '0;
  assign out_valid = out_valid_q;
  assign out_index = out_index_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      end_q       <= '0;
      out_index_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            cur_q   <= first_idx;
            end_q   <= last_idx;
            busy_q  <= 1'b1;
            state_q <= READ;
          end
        end
        READ: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            out_data_q  <= rf_data;
            out_index_q <= cur_q;
            out_valid_q <= 1'b1;
            state_q     <= SEND;
          end
        end
        SEND: begin
          // abort wins over a simultaneous handshake: the word is dropped.
          if (abort) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            if (cur_q == end_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              cur_q   <= cur_q + 5'd1;  // natural 5-bit wrap 31 -> 0
              state_q <= READ;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
module tb_reg_dump_reader;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [4:0]   first_idx = '0;
  logic [4:0]   last_idx = '0;
  logic         abort = 1'b0;
  logic [4:0]   rf_rs;
  logic [N-1:0] rf_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [4:0]   out_index;
  logic [N-1:0] out_data;
  logic         busy;
  logic         done;

  logic [N-1:0] rf [32];
  assign rf_data = rf[rf_rs];

  reg_dump_reader #(.n(N)) dut (
    .clk(clk), .rst(rst), .start(start), .first_idx(first_idx), .last_idx(last_idx),
    .abort(abort), .rf_rs(rf_rs), .rf_data(rf_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_index(out_index), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  // Model: the ordered list of words the current dump must still produce.
  logic [4:0]   exp_idx[$];
  logic [N-1:0] exp_dat[$];
  // Log of words actually accepted by the consumer.
  logic [4:0]   log_idx[$];
  logic [N-1:0] log_dat[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic push_model(input int f, input int l);
    int i = f;
    for (int k = 0; k < 32; k++) begin
      exp_idx.push_back(i[4:0]);
      exp_dat.push_back(rf[i]);
      if (i == l) break;
      i = (i + 1) % 32;
    end
  endtask

  task automatic flush_model();
    exp_idx.delete();
    exp_dat.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dump(input int f, input int l);
    step();
    start     = 1'b1;
    first_idx = f[4:0];
    last_idx  = l[4:0];
    log_idx.delete();
    log_dat.delete();
    push_model(f, l);
  endtask

  // Sample out_valid/done for ncyc cycles; range inputs are scrambled after
  // the start cycle to show they are not re-read.
  task automatic watch(input int ncyc, output logic [63:0] vm, output logic [63:0] dm);
    vm = '0;
    dm = '0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      vm[i] = out_valid;
      dm[i] = done;
      step();
      start     = 1'b0;
      first_idx = 5'($urandom);
      last_idx  = 5'($urandom);
    end
  endtask

  // Compare process: every cycle out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (exp_idx.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word got idx=%0d data=%0h exp=none", out_index, out_data);
        end else begin
          check("word_index", 64'(out_index), 64'(exp_idx[0]));
          check("word_data", 64'(out_data), 64'(exp_dat[0]));
          if (out_ready && !abort) begin
            log_idx.push_back(out_index);
            log_dat.push_back(out_data);
            void'(exp_idx.pop_front());
            void'(exp_dat.pop_front());
          end
        end
      end else if (busy && exp_idx.size() > 0) begin
        check("rf_rs_read", 64'(rf_rs), 64'(exp_idx[0]));
      end
      if (!busy) check("rf_rs_idle", 64'(rf_rs), 64'd0);
      if (done) begin
        check("done_after_last", 64'(exp_idx.size()), 64'd0);
        done_cnt++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] vm, dm;
    int dc;
    rf[0] = '0;
    for (int i = 1; i < 32; i++) rf[i] = N'(32'h100 + i);

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_out_index", 64'(out_index), 0);
    check("rst_out_data", 64'(out_data), 0);
    check("rst_rf_rs", 64'(rf_rs), 0);
    step();
    rst = 1'b0;

    // 3..5, ready held high
    start_dump(3, 5);
    watch(10, vm, dm);
    check("t1_valid_cycles", vm, 64'h54);
    check("t1_done_cycle", dm, 64'h80);
    check("t1_count", 64'(log_idx.size()), 3);
    if (log_idx.size() == 3) begin
      check("t1_w0_idx", 64'(log_idx[0]), 3);
      check("t1_w0_dat", 64'(log_dat[0]), 64'h103);
      check("t1_w2_idx", 64'(log_idx[2]), 5);
      check("t1_w2_dat", 64'(log_dat[2]), 64'h105);
    end

    // Wrapping range 30..1
    start_dump(30, 1);
    watch(12, vm, dm);
    check("t2_valid_cycles", vm, 64'h154);
    check("t2_done_cycle", dm, 64'h200);
    check("t2_count", 64'(log_idx.size()), 4);
    if (log_idx.size() == 4) begin
      check("t2_idx0", 64'(log_idx[0]), 30);
      check("t2_idx1", 64'(log_idx[1]), 31);
      check("t2_idx2", 64'(log_idx[2]), 0);
      check("t2_idx3", 64'(log_idx[3]), 1);
      check("t2_zero_data", 64'(log_dat[2]), 0);
    end

    // Single word with back-pressure
    out_ready = 1'b0;
    start_dump(7, 7);
    watch(7, vm, dm);
    check("t3_valid_held", vm, 64'h7C);
    check("t3_no_early_done", dm, 0);
    out_ready = 1'b1;
    watch(3, vm, dm);
    check("t3_valid_at_ready", vm, 64'h1);
    check("t3_done_after", dm, 64'h2);
    check("t3_count", 64'(log_idx.size()), 1);
    if (log_idx.size() == 1) check("t3_data", 64'(log_dat[0]), 64'h107);

    // Abort during the third SEND, handshake pending
    dc = done_cnt;
    start_dump(0, 31);
    watch(6, vm, dm);
    abort = 1'b1;
    @(negedge clk);
    check("t4_third_send_valid", 64'(out_valid), 1);
    check("t4_third_send_idx", 64'(out_index), 2);
    step();
    abort = 1'b0;
    flush_model();
    @(negedge clk);
    check("t4_abort_valid", 64'(out_valid), 0);
    check("t4_abort_busy", 64'(busy), 0);
    check("t4_abort_done", 64'(done), 0);
    check("t4_accepted", 64'(log_idx.size()), 2);
    watch(4, vm, dm);
    check("t4_quiet_valid", vm, 0);
    check("t4_no_done", 64'(done_cnt - dc), 0);
    start_dump(9, 9);
    watch(5, vm, dm);
    check("t4_restart_valid", vm, 64'h4);
    check("t4_restart_done", dm, 64'h8);
    if (log_idx.size() == 1) check("t4_restart_idx", 64'(log_idx[0]), 9);
    else check("t4_restart_count", 64'(log_idx.size()), 1);

    // Reset on a handshake cycle, with abort and start also high
    dc = done_cnt;
    start_dump(10, 20);
    watch(2, vm, dm);
    rst = 1'b1; start = 1'b1; abort = 1'b1;
    step();
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    flush_model();
    @(negedge clk);
    check("t5_valid", 64'(out_valid), 0);
    check("t5_busy", 64'(busy), 0);
    check("t5_done", 64'(done), 0);
    check("t5_index", 64'(out_index), 0);
    check("t5_data", 64'(out_data), 0);
    check("t5_rf_rs", 64'(rf_rs), 0);
    watch(4, vm, dm);
    check("t5_quiet", vm, 0);
    check("t5_no_done", 64'(done_cnt - dc), 0);

    // Start held high while busy and in DONE is ignored
    start_dump(12, 13);
    vm = '0; dm = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vm[i] = out_valid;
      dm[i] = done;
      step();
      start     = (i < 5);
      first_idx = 5'd0;
      last_idx  = 5'd0;
    end
    start = 1'b0;
    check("t6_valid_cycles", vm, 64'h14);
    check("t6_done_cycle", dm, 64'h20);
    check("t6_count", 64'(log_idx.size()), 2);
    if (log_idx.size() == 2) begin
      check("t6_idx0", 64'(log_idx[0]), 12);
      check("t6_idx1", 64'(log_idx[1]), 13);
    end
    watch(3, vm, dm);
    check("t6_no_restart", vm | dm, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
